// File: rtl/arbiter_pkg.sv
// Shared definitions for the micro-BESM external bus: register indices,
// bus op codes, target FSM states and the semaphore bit position.
package arbiter_pkg;

    typedef enum logic [1:0] {
        ADDR  = 2'd0,
        CMD   = 2'd1,
        RDATA = 2'd2,
        WDATA = 2'd3
    } reg_index_t;

    localparam logic [3:0] FETCH = 4'd8;
    localparam logic [3:0] DRD   = 4'd9;
    localparam logic [3:0] DWR   = 4'd10;
    localparam logic [3:0] RDMWR = 4'd11;
    localparam logic [3:0] BTRWR = 4'd12;
    localparam logic [3:0] BTRRD = 4'd13;

    localparam int SEM_BIT_DEFAULT = 55;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RDOUT = 2'd2
    } target_state_t;

endpackage

// File: rtl/extmem_ram.sv
// Synchronous-read single-port RAM, one-cycle read latency.
module extmem_ram
    import arbiter_pkg::*;
#(
    parameter int AW = 20,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          re,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    // Write port and registered read port share the one address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/extmem_target.sv
// Memory-side responder of the external bus: latches the address on astb,
// does one RAM access per rd/wr strobe, auto-increments for bursts and
// sets the semaphore bit on atomic write-backs.
module extmem_target
    import arbiter_pkg::*;
#(
    parameter int AW      = 20,
    parameter int DW      = 64,
    parameter int SEM_BIT = SEM_BIT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          astb,
    input  logic          rd,
    input  logic          wr,
    input  logic          atomic,
    input  logic [DW-1:0] bus_in,
    output logic [DW-1:0] bus_out,
    output logic          bus_oe,
    output logic [AW-1:0] ram_addr,
    output logic          ram_re,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          locked,
    output logic          err
);

    target_state_t state, state_nxt;
    logic [AW-1:0] addr, addr_nxt;
    logic          lock_nxt;
    logic          err_set;

    // State, address, lock and sticky error registers; reset is active-low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            addr   <= '0;
            locked <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            addr   <= addr_nxt;
            locked <= lock_nxt;
            err    <= err | err_set;
        end
    end

    // Next-state decode plus the combinational RAM and bus drives.
    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        lock_nxt  = locked;
        err_set   = 1'b0;
        ram_addr  = addr;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = bus_in;
        bus_out   = '0;
        bus_oe    = 1'b0;

        if (atomic) begin
            ram_wdata[SEM_BIT] = 1'b1;
        end

        if (state == RDOUT) begin
            bus_out = ram_rdata;
            bus_oe  = 1'b1;
        end

        if (astb) begin
            // Address load always wins; a coincident strobe is a protocol error.
            addr_nxt  = bus_in[AW-1:0];
            state_nxt = ARMED;
            if (rd || wr) begin
                err_set = 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (rd || wr) begin
                        err_set = 1'b1;
                    end
                end
                ARMED: begin
                    if (rd) begin
                        ram_re    = 1'b1;
                        state_nxt = RDOUT;
                        // Atomic reads hold the address for the write-back.
                        if (atomic) begin
                            lock_nxt = 1'b1;
                        end else begin
                            addr_nxt = addr + AW'(1);
                        end
                        if (wr) begin
                            err_set = 1'b1;
                        end
                    end else if (wr) begin
                        ram_we   = 1'b1;
                        addr_nxt = addr + AW'(1);
                        if (atomic) begin
                            lock_nxt = 1'b0;
                        end
                    end
                end
                RDOUT: begin
                    state_nxt = ARMED;
                    if (rd || wr) begin
                        err_set = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        // Initiator abandoning an open RMW breaks the lock and flags an error.
        if (locked && !atomic) begin
            lock_nxt = 1'b0;
            err_set  = 1'b1;
        end
    end

endmodule

// File: tb/tb_extmem_target.sv
// Directed self-checking bench for extmem_target backed by extmem_ram.
module tb_extmem_target;

    localparam int AW = 20;
    localparam int DW = 64;

    logic          clk;
    logic          reset;
    logic          astb, rd, wr, atomic;
    logic [DW-1:0] bus_in;
    logic [DW-1:0] bus_out;
    logic          bus_oe;
    logic [AW-1:0] ram_addr;
    logic          ram_re, ram_we;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          locked, err;

    int compared   = 0;
    int mismatched = 0;

    extmem_target #(.AW(AW), .DW(DW), .SEM_BIT(55)) dut (
        .clk       (clk),
        .reset     (reset),
        .astb      (astb),
        .rd        (rd),
        .wr        (wr),
        .atomic    (atomic),
        .bus_in    (bus_in),
        .bus_out   (bus_out),
        .bus_oe    (bus_oe),
        .ram_addr  (ram_addr),
        .ram_re    (ram_re),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .locked    (locked),
        .err       (err)
    );

    extmem_ram #(.AW(AW), .DW(DW)) ram (
        .clk   (clk),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so a stuck run still ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, settle 1ns.
    task automatic cyc(input logic a, input logic r, input logic w,
                       input logic at, input logic [63:0] d);
        @(negedge clk);
        astb   = a;
        rd     = r;
        wr     = w;
        atomic = at;
        bus_in = d;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        astb = 0; rd = 0; wr = 0; atomic = 0; bus_in = '0;
        #2;
        chk("rst_bus_oe", 64'(bus_oe), 64'd0);
        chk("rst_bus_out", bus_out, 64'd0);
        chk("rst_ram_re", 64'(ram_re), 64'd0);
        chk("rst_ram_we", 64'(ram_we), 64'd0);
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // rd in IDLE: no RAM access, error flagged
        cyc(0, 1, 0, 0, 64'd0);
        chk("idle_rd_no_re", 64'(ram_re), 64'd0);
        cyc(0, 0, 0, 0, 64'd0);
        chk("idle_rd_err", 64'(err), 64'd1);

        // reset pulse clears err
        #1 reset = 1'b0;
        #1 chk("rst_pulse_err", 64'(err), 64'd0);
        reset = 1'b1;

        // single write
        cyc(1, 0, 0, 0, 64'h123);
        chk("astb_no_we", 64'(ram_we), 64'd0);
        cyc(0, 0, 1, 0, 64'hDEADBEEF);
        chk("wr_we", 64'(ram_we), 64'd1);
        chk("wr_addr", 64'(ram_addr), 64'h123);
        chk("wr_data", ram_wdata, 64'hDEADBEEF);

        // single read, one-cycle latency
        cyc(1, 0, 0, 0, 64'h123);
        cyc(0, 1, 0, 0, 64'd0);
        chk("rd_re", 64'(ram_re), 64'd1);
        chk("rd_addr", 64'(ram_addr), 64'h123);
        chk("rd_oe_early", 64'(bus_oe), 64'd0);
        cyc(0, 0, 0, 0, 64'd0);
        chk("rd_oe", 64'(bus_oe), 64'd1);
        chk("rd_data", bus_out, 64'hDEADBEEF);
        cyc(0, 0, 0, 0, 64'd0);
        chk("rd_oe_drop", 64'(bus_oe), 64'd0);

        // preload 0x10..0x12 with a write burst
        cyc(1, 0, 0, 0, 64'h10);
        cyc(0, 0, 1, 0, 64'h1111_0000_0000_0010);
        cyc(0, 0, 1, 0, 64'h2222_0000_0000_0011);
        chk("bwr_addr2", 64'(ram_addr), 64'h11);
        cyc(0, 0, 1, 0, 64'h3333_0000_0000_0012);
        chk("bwr_addr3", 64'(ram_addr), 64'h12);

        // burst read on alternating cycles
        cyc(1, 0, 0, 0, 64'h10);
        cyc(0, 1, 0, 0, 64'd0);
        chk("brd_addr0", 64'(ram_addr), 64'h10);
        cyc(0, 0, 0, 0, 64'd0);
        chk("brd_oe0", 64'(bus_oe), 64'd1);
        chk("brd_data0", bus_out, 64'h1111_0000_0000_0010);
        cyc(0, 1, 0, 0, 64'd0);
        chk("brd_addr1", 64'(ram_addr), 64'h11);
        cyc(0, 0, 0, 0, 64'd0);
        chk("brd_data1", bus_out, 64'h2222_0000_0000_0011);
        cyc(0, 1, 0, 0, 64'd0);
        chk("brd_addr2", 64'(ram_addr), 64'h12);
        cyc(0, 0, 0, 0, 64'd0);
        chk("brd_oe2", 64'(bus_oe), 64'd1);
        chk("brd_data2", bus_out, 64'h3333_0000_0000_0012);

        // atomic RMW on 0x40
        cyc(1, 0, 0, 0, 64'h40);
        cyc(0, 0, 1, 0, 64'd0);
        cyc(1, 0, 0, 1, 64'h40);
        cyc(0, 1, 0, 1, 64'd0);
        chk("rmw_rd_addr", 64'(ram_addr), 64'h40);
        cyc(0, 0, 0, 1, 64'd0);
        chk("rmw_locked", 64'(locked), 64'd1);
        chk("rmw_oe", 64'(bus_oe), 64'd1);
        chk("rmw_rdata", bus_out, 64'd0);
        cyc(0, 0, 1, 1, 64'd0);
        chk("rmw_wr_addr", 64'(ram_addr), 64'h40);
        chk("rmw_wr_we", 64'(ram_we), 64'd1);
        chk("rmw_wr_oe", 64'(bus_oe), 64'd0);
        chk("rmw_wr_data", ram_wdata, 64'h0080_0000_0000_0000);
        cyc(0, 0, 0, 0, 64'd0);
        chk("rmw_unlock", 64'(locked), 64'd0);
        chk("rmw_err", 64'(err), 64'd0);

        // address wrap
        cyc(1, 0, 0, 0, 64'hFFFFF);
        cyc(0, 0, 1, 0, 64'hA);
        chk("wrap_addr0", 64'(ram_addr), 64'hFFFFF);
        cyc(0, 0, 1, 0, 64'hB);
        chk("wrap_addr1", 64'(ram_addr), 64'h0);
        chk("wrap_we1", 64'(ram_we), 64'd1);
        cyc(0, 0, 0, 0, 64'd0);
        chk("wrap_err", 64'(err), 64'd0);

        // astb with wr: load wins, no write, error
        cyc(1, 0, 1, 0, 64'h200);
        chk("astbwr_no_we", 64'(ram_we), 64'd0);
        cyc(0, 1, 0, 0, 64'd0);
        chk("astbwr_err", 64'(err), 64'd1);
        chk("astbwr_addr", 64'(ram_addr), 64'h200);
        chk("astbwr_re", 64'(ram_re), 64'd1);
        cyc(0, 0, 0, 0, 64'd0);

        // atomic dropped while locked
        #1 reset = 1'b0;
        #1 chk("rst2_err", 64'(err), 64'd0);
        reset = 1'b1;
        cyc(1, 0, 0, 1, 64'h40);
        cyc(0, 1, 0, 1, 64'd0);
        cyc(0, 0, 0, 1, 64'd0);
        chk("drop_locked", 64'(locked), 64'd1);
        cyc(0, 0, 0, 0, 64'd0);
        cyc(0, 0, 0, 0, 64'd0);
        chk("drop_unlock", 64'(locked), 64'd0);
        chk("drop_err", 64'(err), 64'd1);

        // asynchronous reset in the middle of RDOUT
        cyc(1, 0, 0, 1, 64'h123);
        cyc(0, 1, 0, 1, 64'd0);
        cyc(0, 0, 0, 1, 64'd0);
        chk("ar_pre_oe", 64'(bus_oe), 64'd1);
        chk("ar_pre_locked", 64'(locked), 64'd1);
        #1 reset = 1'b0;
        #1;
        chk("ar_oe", 64'(bus_oe), 64'd0);
        chk("ar_locked", 64'(locked), 64'd0);
        chk("ar_re", 64'(ram_re), 64'd0);
        chk("ar_we", 64'(ram_we), 64'd0);
        chk("ar_err", 64'(err), 64'd0);
        atomic = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
